bht_access_scheduler: RTL and testbench
=======================================

Name: bht_access_scheduler

Overview:
Controller that owns an M-entry table of N-bit saturating branch counters behind a single access port. It shares that port between fetch-side lookups and execute-side resolve updates. It tracks in-flight predictions in an in-order queue and maintains prediction-accuracy statistics. It sits between the fetch stage (lookups) and the branch unit (resolves).

Parameters:
M, 64, number of table entries (power of 2, ≥2)
N, 2, bits per counter (1 or 2)
Q, 4, max in-flight unresolved predictions (power of 2)
PC_W, 9, width of lk_pc

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous; discards all in-flight queue entries
lk_valid  input  1  fetch lookup request
lk_pc  input  PC_W  lookup PC; index = lk_pc[$clog2(M)-1:0]
lk_ready  output  1  lookup accepted when lk_valid & lk_ready
pred_valid  output  1  one-cycle pulse, prediction available
pred_taken  output  1  predicted direction
res_valid  input  1  branch resolution for the oldest in-flight entry
res_taken  input  1  actual outcome
res_ready  output  1  resolve accepted when res_valid & res_ready
inflight  output  $clog2(Q)+1  current queue occupancy
busy  output  1  FSM not in IDLE
total_predictions  output  32  resolves retired
correct_predictions  output  32  resolves where prediction matched outcome

Behaviour:
- Reset (async):
  - Every counter = weakly not-taken (N=2: 2'b01; N=1: 1'b0).
  - Queue empty; FSM = IDLE.
  - pred_valid=0, pred_taken=0, inflight=0, busy=0, both statistics counters=0.
- FSM states:
  - IDLE -> UPD_RD on resolve accept.
  - UPD_RD -> UPD_WR, unconditionally.
  - UPD_WR -> IDLE.
- The port does exactly one access per cycle: a lookup read in IDLE, a counter read in UPD_RD, or a counter write in UPD_WR.
- res_ready = (state==IDLE) & (inflight!=0) & !flush.
- lk_ready = (state==IDLE) & (inflight<Q) & !flush & !(res_valid & inflight!=0).
  - Resolve has strict priority over lookup.
- Lookup accept, cycle T:
  - Table read at the index.
  - Next cycle (T+1): pred_valid=1 and pred_taken = counter MSB.
  - Push {index, pred_taken} into the queue; the entry is visible in inflight at T+1.
  - pred_taken holds its value until the next pred_valid.
- Resolve accept, cycle T:
  - Pop the queue head into a holding register, together with res_taken.
  - UPD_RD (T+1): read the counter at the held index.
  - UPD_WR (T+2): write the updated counter.
    - Taken: +1, saturating at 2^N-1.
    - Not taken: -1, saturating at 0.
  - Also at UPD_WR: total_predictions+1; correct_predictions+1 if held pred == held outcome.
  - Back in IDLE at T+3, so the minimum resolve-to-resolve spacing is 3 cycles.
- Lookup in the same cycle the counter at that index is written: cannot happen, because lookups are only accepted in IDLE.
- Queue full (inflight==Q): lk_ready=0.
- Queue empty: res_ready=0; res_valid is ignored and has no effect.
- flush:
  - Queue emptied at the next edge (inflight=0), in any state.
  - An update already in UPD_RD/UPD_WR completes normally, because its entry was already popped.
  - A pred_valid pulse due in that cycle still fires, but its entry is discarded.
  - flush has priority over push and pop in the same cycle.
- Statistics counters wrap modulo 2^32. flush does not clear them.
- Queue pointers wrap modulo Q. Push and pop never coincide, because pop happens only on resolve accept and push only on lookup accept.
- Reset asserted mid-update: the update is aborted and all state is reinitialised immediately.

Test Plan:
1. After reset, lookup pc=0x005 -> lk_ready=1; next cycle pred_valid=1, pred_taken=0, inflight=1.
2. Three resolves taken=1 at index 5, each preceded by a lookup (N=2) -> counter 01->10->11->11 (saturates). Predictions 0,1,1; total=3, correct=2.
3. Four lookups with no resolve (Q=4) -> inflight=4 and lk_ready=0; one resolve -> lk_ready returns 1 in IDLE after the 3-cycle update.
4. res_valid and lk_valid asserted together with inflight=2 -> resolve accepted, lookup stalled 3 cycles, busy=1 during UPD_RD/UPD_WR.
5. Two in flight, flush during UPD_RD of the older one -> that update completes (total+1), inflight=0, res_ready=0, later res_valid ignored.
6. Reset asserted during UPD_WR -> immediately busy=0, inflight=0, counters=0, table re-initialised (lookup at that index predicts 0).

Source files
------------

// File: rtl/bht_access_scheduler.sv
// Branch history table controller: one access port shared between fetch lookups and
// resolve read-modify-write updates, with an in-order in-flight queue and accuracy stats.
module bht_access_scheduler #(
  parameter int unsigned M    = 64,
  parameter int unsigned N    = 2,
  parameter int unsigned Q    = 4,
  parameter int unsigned PC_W = 9
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_flush,
  input  logic                 i_lk_valid,
  input  logic [PC_W-1:0]      i_lk_pc,
  output logic                 o_lk_ready,
  output logic                 o_pred_valid,
  output logic                 o_pred_taken,
  input  logic                 i_res_valid,
  input  logic                 i_res_taken,
  output logic                 o_res_ready,
  output logic [$clog2(Q):0]   o_inflight,
  output logic                 o_busy,
  output logic [31:0]          o_total_predictions,
  output logic [31:0]          o_correct_predictions
);

  localparam int unsigned IW = $clog2(M);
  localparam int unsigned QW = (Q > 1) ? $clog2(Q) : 1;
  localparam int unsigned CW = $clog2(Q) + 1;
  localparam logic [N-1:0] WeakNt = N'((N == 2) ? 1 : 0);
  localparam logic [N-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StUpdRd, StUpdWr} state_e;

  state_e          r_state, w_state_next;
  logic [N-1:0]    r_table [M];
  logic [IW-1:0]   r_q_idx [Q];
  logic            r_q_pred [Q];
  logic [QW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [IW-1:0]   r_h_idx;
  logic            r_h_pred, r_h_out;
  logic [N-1:0]    r_rd_cnt;
  logic            r_pred_valid, r_pred_taken;
  logic [31:0]     r_total, r_correct;

  logic [IW-1:0]   w_idx;
  logic            w_lk_pred, w_lk_acc, w_res_acc, w_nonempty;
  logic [N-1:0]    w_upd_cnt;

  assign w_idx      = i_lk_pc[IW-1:0];
  assign w_lk_pred  = r_table[w_idx][N-1];
  assign w_nonempty = (r_count != '0);

  // Resolve wins the port over a lookup presented in the same cycle.
  assign o_res_ready = (r_state == StIdle) & w_nonempty & ~i_flush;
  assign o_lk_ready  = (r_state == StIdle) & (r_count < CW'(Q)) & ~i_flush &
                       ~(i_res_valid & w_nonempty);
  assign w_lk_acc    = i_lk_valid & o_lk_ready;
  assign w_res_acc   = i_res_valid & o_res_ready;

  assign o_inflight            = r_count;
  assign o_busy                = (r_state != StIdle);
  assign o_pred_valid          = r_pred_valid;
  assign o_pred_taken          = r_pred_taken;
  assign o_total_predictions   = r_total;
  assign o_correct_predictions = r_correct;

  always_comb begin
    w_upd_cnt = r_rd_cnt;
    if (r_h_out) begin
      if (r_rd_cnt != CntMax) w_upd_cnt = r_rd_cnt + N'(1);
    end else begin
      if (r_rd_cnt != '0) w_upd_cnt = r_rd_cnt - N'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_res_acc) w_state_next = StUpdRd;
      StUpdRd: w_state_next = StUpdWr;
      StUpdWr: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= StIdle;
    else         r_state <= w_state_next;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < M; i++) r_table[i] <= WeakNt;
    end else if (r_state == StUpdWr) begin
      r_table[r_h_idx] <= w_upd_cnt;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < Q; i++) begin
        r_q_idx[i]  <= '0;
        r_q_pred[i] <= 1'b0;
      end
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_h_idx      <= '0;
      r_h_pred     <= 1'b0;
      r_h_out      <= 1'b0;
      r_rd_cnt     <= '0;
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
      r_total      <= '0;
      r_correct    <= '0;
    end else begin
      r_pred_valid <= w_lk_acc;
      if (w_lk_acc) begin
        r_pred_taken       <= w_lk_pred;
        r_q_idx[r_wr_ptr]  <= w_idx;
        r_q_pred[r_wr_ptr] <= w_lk_pred;
      end
      if (w_res_acc) begin
        r_h_idx  <= r_q_idx[r_rd_ptr];
        r_h_pred <= r_q_pred[r_rd_ptr];
        r_h_out  <= i_res_taken;
      end
      if (r_state == StUpdRd) r_rd_cnt <= r_table[r_h_idx];
      if (r_state == StUpdWr) begin
        r_total <= r_total + 32'd1;
        if (r_h_pred == r_h_out) r_correct <= r_correct + 32'd1;
      end
      // Flush drops everything queued; an already-popped update still finishes.
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_lk_acc) begin
          r_wr_ptr <= r_wr_ptr + QW'(1);
          r_count  <= r_count + CW'(1);
        end else if (w_res_acc) begin
          r_rd_ptr <= r_rd_ptr + QW'(1);
          r_count  <= r_count - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bht_access_scheduler.sv
// Bench for bht_access_scheduler: vector table, directed corner sequences and a random
// run, all checked against a transaction-level model of the table and in-flight queue.
module tb_bht_access_scheduler;

  localparam int unsigned M = 64, N = 2, Q = 4, PC_W = 9;
  localparam int CMAX = (1 << N) - 1;

  logic            clk = 1'b0;
  logic            reset, flush, lk_valid, res_valid, res_taken;
  logic [PC_W-1:0] lk_pc;
  logic            lk_ready, pred_valid, pred_taken, res_ready, busy;
  logic [$clog2(Q):0] inflight;
  logic [31:0]     total, correct;

  bht_access_scheduler #(.M(M), .N(N), .Q(Q), .PC_W(PC_W)) dut (
    .i_clk(clk), .i_reset(reset), .i_flush(flush), .i_lk_valid(lk_valid), .i_lk_pc(lk_pc),
    .o_lk_ready(lk_ready), .o_pred_valid(pred_valid), .o_pred_taken(pred_taken),
    .i_res_valid(res_valid), .i_res_taken(res_taken), .o_res_ready(res_ready),
    .o_inflight(inflight), .o_busy(busy), .o_total_predictions(total),
    .o_correct_predictions(correct)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counter values, FIFO of outstanding predictions, update countdown.
  typedef struct {int idx; bit pred;} ent_t;
  int          m_tab[M];
  ent_t        m_q[$];
  int          m_busy_cnt;
  ent_t        m_hold;
  bit          m_hold_out;
  bit          m_pv, m_pt;
  int unsigned m_total, m_correct;

  task automatic model_reset();
    for (int i = 0; i < M; i++) m_tab[i] = (N == 2) ? 1 : 0;
    m_q.delete();
    m_busy_cnt = 0;
    m_pv = 0; m_pt = 0;
    m_total = 0; m_correct = 0;
  endtask

  function automatic bit m_res_ready(input bit fl);
    return m_busy_cnt == 0 && m_q.size() != 0 && !fl;
  endfunction

  function automatic bit m_lk_ready(input bit rv, input bit fl);
    return m_busy_cnt == 0 && m_q.size() < Q && !fl && !(rv && m_q.size() != 0);
  endfunction

  task automatic model_step(input bit lkv, input int idx, input bit rv, input bit rt,
                            input bit fl);
    bit lacc, racc;
    lacc = lkv && m_lk_ready(rv, fl);
    racc = rv && m_res_ready(fl);
    m_pv = 0;
    if (m_busy_cnt == 1) begin
      if (m_hold_out) m_tab[m_hold.idx] = (m_tab[m_hold.idx] == CMAX) ? CMAX : m_tab[m_hold.idx] + 1;
      else            m_tab[m_hold.idx] = (m_tab[m_hold.idx] == 0) ? 0 : m_tab[m_hold.idx] - 1;
      m_total++;
      if (m_hold.pred == m_hold_out) m_correct++;
    end
    if (m_busy_cnt > 0) m_busy_cnt--;
    if (racc) begin
      m_hold = m_q.pop_front();
      m_hold_out = rt;
      m_busy_cnt = 2;
    end
    if (lacc) begin
      ent_t e;
      e.idx = idx;
      e.pred = (m_tab[idx] >> (N - 1)) & 1;
      m_q.push_back(e);
      m_pv = 1;
      m_pt = e.pred;
    end
    if (fl) m_q.delete();
  endtask

  logic s_lkr, s_rsr;

  // One clock: drive, check ready outputs pre-edge, clock, check registered outputs.
  task automatic cycle(input bit lkv, input logic [PC_W-1:0] pc, input bit rv, input bit rt,
                       input bit fl);
    lk_valid = lkv; lk_pc = pc; res_valid = rv; res_taken = rt; flush = fl;
    #1;
    s_lkr = lk_ready;
    s_rsr = res_ready;
    chk("lk_ready", 32'(lk_ready), 32'(m_lk_ready(rv, fl)));
    chk("res_ready", 32'(res_ready), 32'(m_res_ready(fl)));
    model_step(lkv, int'(pc) % M, rv, rt, fl);
    @(posedge clk); #1;
    chk("pred_valid", 32'(pred_valid), 32'(m_pv));
    if (m_pv) chk("pred_taken", 32'(pred_taken), 32'(m_pt));
    chk("inflight", 32'(inflight), m_q.size());
    chk("busy", 32'(busy), 32'(m_busy_cnt != 0));
    chk("total", total, m_total);
    chk("correct", correct, m_correct);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    lk_valid = 0; lk_pc = '0; res_valid = 0; res_taken = 0; flush = 0;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  typedef struct {
    bit lkv; logic [PC_W-1:0] pc; bit rv; bit rt; bit fl;
    bit e_lkr; bit e_rsr; bit e_pv; bit e_pt; int e_inf; bit e_busy;
  } vec_t;
  vec_t vecs[13];

  initial begin
    // Index 5 trained three times taken; final lookup aliases via pc 0x105.
    vecs[0]  = '{1, 9'h005, 0, 0, 0, 1, 0, 1, 0, 1, 0};
    vecs[1]  = '{0, 9'h000, 1, 1, 0, 0, 1, 0, 0, 0, 1};
    vecs[2]  = '{0, 9'h000, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    vecs[3]  = '{0, 9'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[4]  = '{1, 9'h005, 0, 0, 0, 1, 0, 1, 1, 1, 0};
    vecs[5]  = '{0, 9'h000, 1, 1, 0, 0, 1, 0, 1, 0, 1};
    vecs[6]  = '{0, 9'h000, 0, 0, 0, 0, 0, 0, 1, 0, 1};
    vecs[7]  = '{0, 9'h000, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[8]  = '{1, 9'h005, 0, 0, 0, 1, 0, 1, 1, 1, 0};
    vecs[9]  = '{0, 9'h000, 1, 1, 0, 0, 1, 0, 1, 0, 1};
    vecs[10] = '{0, 9'h000, 0, 0, 0, 0, 0, 0, 1, 0, 1};
    vecs[11] = '{0, 9'h000, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[12] = '{1, 9'h105, 0, 0, 0, 1, 0, 1, 1, 1, 0};

    do_reset();
    chk("rst_inflight", 32'(inflight), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pred_valid", 32'(pred_valid), 0);
    chk("rst_pred_taken", 32'(pred_taken), 0);
    chk("rst_total", total, 0);
    chk("rst_correct", correct, 0);

    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].lkv, vecs[i].pc, vecs[i].rv, vecs[i].rt, vecs[i].fl);
      chk($sformatf("vec%0d_lk_ready", i), 32'(s_lkr), 32'(vecs[i].e_lkr));
      chk($sformatf("vec%0d_res_ready", i), 32'(s_rsr), 32'(vecs[i].e_rsr));
      chk($sformatf("vec%0d_pred_valid", i), 32'(pred_valid), 32'(vecs[i].e_pv));
      chk($sformatf("vec%0d_pred_taken", i), 32'(pred_taken), 32'(vecs[i].e_pt));
      chk($sformatf("vec%0d_inflight", i), 32'(inflight), vecs[i].e_inf);
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
    end
    chk("train_total", total, 3);
    chk("train_correct", correct, 2);

    // Queue full stalls lookups until one resolve retires.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, PC_W'(i), 0, 0, 0);
    chk("full_inflight", 32'(inflight), 4);
    cycle(1, 9'h010, 0, 0, 0);
    chk("full_lk_ready", 32'(s_lkr), 0);
    cycle(1, 9'h010, 1, 0, 0);
    chk("full_res_ready", 32'(s_rsr), 1);
    cycle(1, 9'h010, 0, 0, 0);
    chk("full_stall_rd", 32'(s_lkr), 0);
    cycle(1, 9'h010, 0, 0, 0);
    chk("full_stall_wr", 32'(s_lkr), 0);
    cycle(1, 9'h010, 0, 0, 0);
    chk("full_lk_resume", 32'(s_lkr), 1);

    // Simultaneous resolve and lookup: resolve wins, lookup waits out the update.
    do_reset();
    cycle(1, 9'h001, 0, 0, 0);
    cycle(1, 9'h002, 0, 0, 0);
    cycle(1, 9'h003, 1, 1, 0);
    chk("prio_lk_ready", 32'(s_lkr), 0);
    chk("prio_res_ready", 32'(s_rsr), 1);
    chk("prio_busy_rd", 32'(busy), 1);
    cycle(1, 9'h003, 0, 0, 0);
    chk("prio_busy_wr", 32'(busy), 1);
    cycle(1, 9'h003, 0, 0, 0);
    chk("prio_busy_idle", 32'(busy), 0);
    cycle(1, 9'h003, 0, 0, 0);
    chk("prio_lk_accept", 32'(s_lkr), 1);

    // Flush during an update: update retires, queue empties, later resolves ignored.
    do_reset();
    cycle(1, 9'h008, 0, 0, 0);
    cycle(1, 9'h009, 0, 0, 0);
    cycle(0, '0, 1, 0, 0);
    cycle(0, '0, 0, 0, 1);
    chk("flush_inflight", 32'(inflight), 0);
    idle(2);
    chk("flush_total", total, 1);
    cycle(0, '0, 1, 1, 0);
    chk("flush_res_ready", 32'(s_rsr), 0);
    idle(3);
    chk("flush_total_after", total, 1);

    // Reset in the middle of an update write.
    do_reset();
    cycle(1, 9'h007, 0, 0, 0);
    cycle(0, '0, 1, 1, 0);
    cycle(1, 9'h007, 0, 0, 0);
    cycle(1, 9'h007, 0, 0, 0);
    cycle(1, 9'h007, 0, 0, 0);
    chk("pre_rst_pred", 32'(pred_taken), 1);
    cycle(0, '0, 1, 1, 0);
    cycle(0, '0, 0, 0, 0);
    chk("pre_rst_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_inflight", 32'(inflight), 0);
    chk("midrst_total", total, 0);
    chk("midrst_correct", correct, 0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    cycle(1, 9'h007, 0, 0, 0);
    chk("midrst_table", 32'(pred_taken), 0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) < 6, PC_W'($urandom), $urandom_range(0, 9) < 4,
            1'($urandom), $urandom_range(0, 99) < 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
